bg_fetch_sched: RTL and testbench
=================================

Name: bg_fetch_sched

Overview:
- Scheduler that shares the single combinational bias/gate buffer ROM between two LSTM gate-compute requesters.
- Accepts burst requests of the form (base row, row count). Arbitrates round-robin between the two requesters.
- Drives the ROM address and streams the packed UNITS_NUM*D_WL row words out through a registered valid/ready port, with requester id and last tags.
- Sits between the bias buffer and the gate accumulators of the LSTM layer datapath.

Parameters:
- D_WL, 24, bit width of one unit's bias word.
- UNITS_NUM, 5, number of unit words packed per ROM row.
- ROWS, 6, number of valid ROM rows (0..ROWS-1).
- AW, 8, ROM address width.
- LW, 4, burst-length field width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0  in  1  requester 0 burst request; level, held until gnt0.
- base0  in  AW  requester 0 first row.
- len0  in  LW  requester 0 row count.
- req1  in  1  requester 1 burst request.
- base1  in  AW  requester 1 first row.
- len1  in  LW  requester 1 row count.
- gnt0  out  1  one-cycle acceptance pulse for requester 0.
- gnt1  out  1  one-cycle acceptance pulse for requester 1.
- bb_addr  out  AW  ROM row address.
- bb_w  in  UNITS_NUM*D_WL  ROM row data (combinational from bb_addr).
- out_data  out  UNITS_NUM*D_WL  registered row word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts a beat when out_valid && out_ready.
- out_id  out  1  requester that owns the beat.
- out_last  out  1  final beat of the burst.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse when a request is rejected.

Behaviour:
- Reset values: state=IDLE; all outputs 0; rr pointer=1, so requester 0 wins the first tie.
- FSM states: IDLE, BURST, DRAIN.
- IDLE:
  - bb_addr=0.
  - If only one req is high, that requester is selected.
  - If both are high, the requester other than rr is selected; rr is updated to the winner.
  - On the edge after selection: gntX=1 for exactly one cycle; base, len and id are latched.
  - Legality: the request is legal iff len!=0 and base+len<=ROWS, evaluated at LW+AW+1 bits with no wrap.
  - Illegal request: err=1 together with gnt in the same cycle; no beats are produced; state stays IDLE.
  - Legal request: cur=base, remaining=len, go to BURST.
- BURST:
  - bb_addr=cur.
  - Load condition: !out_valid || out_ready.
  - On load: out_data<=bb_w, out_valid<=1, out_id<=id, out_last<=(remaining==1); then cur++ and remaining--.
  - If the loaded beat is last, go to DRAIN.
  - With no load, cur is held and bb_addr is stable.
- DRAIN: when out_valid && out_ready, clear out_valid and out_last and go to IDLE.
- Latency: first out_valid occurs one cycle after the gnt cycle.
- Throughput: 1 beat/cycle with out_ready=1. An N-row burst occupies N+1 cycles from gnt to last accept, plus one IDLE cycle before the next gnt.
- Data stability: out_data/id/last are held stable while out_valid && !out_ready.
- Request protocol:
  - A req dropped before its gnt is simply not served.
  - Reqs are ignored outside IDLE.
  - A req held after its gnt starts a new burst.
- Asynchronous reset at any point, including mid-burst, returns all state to reset values immediately. A partial burst is abandoned and no out_last is issued.
- bb_addr never exceeds ROWS-1.

Test Plan:
- req0 base=0 len=6, out_ready=1 -> gnt0 one cycle; 6 beats on consecutive cycles, rows 0..5, first out_data='h00017cffedda00030800089afffabe, last='hfffd9e0001b200028cfffeadfff993; out_last only on beat 6; out_id=0; busy falls after the last accept.
- req1 base=2 len=2, out_ready toggles 1,0,0,1 -> beat row 2 ('h0007020000c4fffe3dfff826000302) is held stable across the stall; row 3 ('h00062e0005a700068500025f0005ba) follows with out_last=1; no beat is lost or duplicated.
- req0 and req1 both held after reset, each len=1 -> grants alternate 0,1,0,1; out_id matches each grant.
- req0 base=5 len=2, then base=3 len=0 -> err+gnt0 pulse each time; out_valid stays 0; FSM stays in IDLE. Then base=5 len=1 -> a single beat 'hfffd9e0001b200028cfffeadfff993 with out_last=1.
- rst asserted asynchronously after beat 2 of a len=6 burst -> outputs clear without waiting for a clock edge. After release, a new req1 len=1 is served from IDLE with rr=1 tie behaviour.

Source files
------------

// File: rtl/bg_fetch_sched_if.sv
// Port bundle for bg_fetch_sched: two burst requesters, the bias ROM
// address/data pair and the registered row-word output stream.
interface bg_fetch_sched_if #(
    parameter int D_WL      = 24,
    parameter int UNITS_NUM = 5,
    parameter int AW        = 8,
    parameter int LW        = 4
);
    logic                      req0;
    logic [AW-1:0]             base0;
    logic [LW-1:0]             len0;
    logic                      req1;
    logic [AW-1:0]             base1;
    logic [LW-1:0]             len1;
    logic                      gnt0;
    logic                      gnt1;
    logic [AW-1:0]             bb_addr;
    logic [UNITS_NUM*D_WL-1:0] bb_w;
    logic [UNITS_NUM*D_WL-1:0] out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic                      out_id;
    logic                      out_last;
    logic                      busy;
    logic                      err;

    // master = requesters, ROM and consumer side; slave = the scheduler
    modport master (
        output req0, base0, len0, req1, base1, len1, bb_w, out_ready,
        input  gnt0, gnt1, bb_addr, out_data, out_valid, out_id, out_last, busy, err
    );

    modport slave (
        input  req0, base0, len0, req1, base1, len1, bb_w, out_ready,
        output gnt0, gnt1, bb_addr, out_data, out_valid, out_id, out_last, busy, err
    );
endinterface

// File: rtl/bg_fetch_sched.sv
// Round-robin burst scheduler sharing the combinational bias ROM between two
// LSTM gate-compute requesters; streams rows out through a registered valid/ready port.
//
// state | meaning
// IDLE  | waiting for a request; selects, grants and checks legality
// BURST | driving bb_addr=cur and loading one row per accepted beat
// DRAIN | last beat loaded, waiting for its acceptance
module bg_fetch_sched #(
    parameter int D_WL      = 24,
    parameter int UNITS_NUM = 5,
    parameter int ROWS      = 6,
    parameter int AW        = 8,
    parameter int LW        = 4
) (
    input  logic             clk,
    input  logic             rst,
    bg_fetch_sched_if.slave  bus
);
    localparam int RW = UNITS_NUM * D_WL;
    localparam int SW = AW + LW + 1;
    localparam logic [SW-1:0] ROWS_W = SW'(ROWS);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] cur_q;
    logic [LW-1:0] rem_q;
    logic          id_q;
    logic          rr_q;

    logic          sel_valid;
    logic          sel_tie;
    logic          sel_id;
    logic [AW-1:0] sel_base;
    logic [LW-1:0] sel_len;
    logic [SW-1:0] sel_end;
    logic          legal;
    logic          load;
    logic          accept;
    logic [RW-1:0] row_d;

    assign sel_valid = bus.req0 | bus.req1;
    assign sel_tie   = bus.req0 & bus.req1;
    // on a tie the requester that did not win last time goes first
    assign sel_id    = sel_tie ? ~rr_q : bus.req1;
    assign sel_base  = sel_id ? bus.base1 : bus.base0;
    assign sel_len   = sel_id ? bus.len1 : bus.len0;
    assign sel_end   = SW'(sel_base) + SW'(sel_len);
    assign legal     = (sel_len != '0) && (sel_end <= ROWS_W);

    assign load      = (state_q == BURST) && (!bus.out_valid || bus.out_ready);
    assign accept    = bus.out_valid && bus.out_ready;
    assign row_d     = bus.bb_w;

    assign bus.bb_addr = (state_q == BURST) ? cur_q : '0;
    assign bus.busy    = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sel_valid && legal) state_d = BURST;
            BURST:   if (load && rem_q == LW'(1)) state_d = DRAIN;
            DRAIN:   if (accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q         <= '0;
            rem_q         <= '0;
            id_q          <= 1'b0;
            rr_q          <= 1'b1;
            bus.gnt0      <= 1'b0;
            bus.gnt1      <= 1'b0;
            bus.err       <= 1'b0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_id    <= 1'b0;
            bus.out_last  <= 1'b0;
        end else begin
            bus.gnt0 <= 1'b0;
            bus.gnt1 <= 1'b0;
            bus.err  <= 1'b0;
            if (state_q == IDLE && sel_valid) begin
                bus.gnt0 <= ~sel_id;
                bus.gnt1 <= sel_id;
                bus.err  <= ~legal;
                cur_q    <= sel_base;
                rem_q    <= sel_len;
                id_q     <= sel_id;
                if (sel_tie) rr_q <= sel_id;
            end
            if (load) begin
                bus.out_data  <= row_d;
                bus.out_valid <= 1'b1;
                bus.out_id    <= id_q;
                bus.out_last  <= (rem_q == LW'(1));
                cur_q         <= cur_q + AW'(1);
                rem_q         <= rem_q - LW'(1);
            end else if (state_q == DRAIN && accept) begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bg_fetch_sched.sv
// Directed bench for bg_fetch_sched: ROM model on bb_addr, per-scenario tasks
// with hand-derived beat sequences sampled on the falling edge.
module tb_bg_fetch_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bg_fetch_sched_if bif ();

    bg_fetch_sched dut (.clk(clk), .rst(rst), .bus(bif.slave));

    always #5 clk = ~clk;

    function automatic logic [119:0] rom_row(input logic [7:0] a);
        case (a)
            8'd0:    return 120'h00017cffedda00030800089afffabe;
            8'd1:    return 120'h111111222222333333444444555555;
            8'd2:    return 120'h0007020000c4fffe3dfff826000302;
            8'd3:    return 120'h00062e0005a700068500025f0005ba;
            8'd4:    return 120'h0a0a0a0b0b0b0c0c0c0d0d0d0e0e0e;
            8'd5:    return 120'hfffd9e0001b200028cfffeadfff993;
            default: return 120'hdeaddeaddeaddeaddeaddeaddeadde;
        endcase
    endfunction

    assign bif.bb_w = rom_row(bif.bb_addr);

    task automatic wait_gnt();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bif.gnt0 || bif.gnt1) break;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (bif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bif.out_valid); end
        checks++; if (bif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bif.busy); end
        checks++; if ({bif.gnt0, bif.gnt1, bif.err, bif.out_last, bif.out_id} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {bif.gnt0, bif.gnt1, bif.err, bif.out_last, bif.out_id}); end
        checks++; if (bif.bb_addr !== 8'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", bif.bb_addr); end
        checks++; if (bif.out_data !== 120'h0) begin errors++; $display("FAIL reset_data got %h exp 0", bif.out_data); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_burst();
        bif.out_ready = 1'b1;
        bif.req0 = 1'b1; bif.base0 = 8'd0; bif.len0 = 4'd6;
        wait_gnt();
        checks++; if ({bif.gnt0, bif.gnt1, bif.err} !== 3'b100) begin errors++; $display("FAIL full_gnt got %b exp 100", {bif.gnt0, bif.gnt1, bif.err}); end
        bif.req0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (bif.out_valid !== 1'b1 || bif.out_data !== rom_row(8'(i))) begin errors++; $display("FAIL full_beat%0d got v=%b %h exp v=1 %h", i, bif.out_valid, bif.out_data, rom_row(8'(i))); end
            checks++; if (bif.out_last !== (i == 5) || bif.out_id !== 1'b0 || bif.busy !== 1'b1) begin errors++; $display("FAIL full_tag%0d got last=%b id=%b busy=%b exp last=%b id=0 busy=1", i, bif.out_last, bif.out_id, bif.busy, i == 5); end
            if (i == 0) begin
                checks++; if (bif.gnt0 !== 1'b0) begin errors++; $display("FAIL full_gnt_pulse got %b exp 0", bif.gnt0); end
            end
        end
        @(negedge clk);
        checks++; if (bif.out_valid !== 1'b0 || bif.busy !== 1'b0) begin errors++; $display("FAIL full_end got v=%b busy=%b exp 0 0", bif.out_valid, bif.busy); end
    endtask

    task automatic test_stall();
        logic       ready_seq [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] row_seq   [5] = '{8'd2, 8'd2, 8'd2, 8'd3, 8'd0};
        logic       val_seq   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       last_seq  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        bif.req1 = 1'b1; bif.base1 = 8'd2; bif.len1 = 4'd2;
        wait_gnt();
        checks++; if ({bif.gnt0, bif.gnt1, bif.err} !== 3'b010) begin errors++; $display("FAIL stall_gnt got %b exp 010", {bif.gnt0, bif.gnt1, bif.err}); end
        bif.req1 = 1'b0;
        bif.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (bif.out_valid !== val_seq[i]) begin errors++; $display("FAIL stall_valid%0d got %b exp %b", i, bif.out_valid, val_seq[i]); end
            if (val_seq[i]) begin
                checks++; if (bif.out_data !== rom_row(row_seq[i]) || bif.out_last !== last_seq[i] || bif.out_id !== 1'b1) begin errors++; $display("FAIL stall_beat%0d got %h last=%b id=%b exp %h last=%b id=1", i, bif.out_data, bif.out_last, bif.out_id, rom_row(row_seq[i]), last_seq[i]); end
            end
            if (i == 1) begin
                checks++; if (bif.bb_addr !== 8'd3) begin errors++; $display("FAIL stall_addr got %0d exp 3", bif.bb_addr); end
            end
            bif.out_ready = ready_seq[i];
        end
        bif.out_ready = 1'b1;
    endtask

    task automatic test_alternate();
        logic exp_id [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        bif.req0 = 1'b1; bif.base0 = 8'd1; bif.len0 = 4'd1;
        bif.req1 = 1'b1; bif.base1 = 8'd4; bif.len1 = 4'd1;
        for (int g = 0; g < 4; g++) begin
            wait_gnt();
            checks++; if ({bif.gnt0, bif.gnt1} !== {~exp_id[g], exp_id[g]}) begin errors++; $display("FAIL alt_gnt%0d got %b%b exp %b%b", g, bif.gnt0, bif.gnt1, ~exp_id[g], exp_id[g]); end
            @(negedge clk);
            checks++; if (bif.out_valid !== 1'b1 || bif.out_id !== exp_id[g] || bif.out_last !== 1'b1 || bif.out_data !== rom_row(exp_id[g] ? 8'd4 : 8'd1)) begin errors++; $display("FAIL alt_beat%0d got v=%b id=%b last=%b %h exp v=1 id=%b last=1 %h", g, bif.out_valid, bif.out_id, bif.out_last, bif.out_data, exp_id[g], rom_row(exp_id[g] ? 8'd4 : 8'd1)); end
        end
        bif.req0 = 1'b0; bif.req1 = 1'b0;
        @(negedge clk);
        checks++; if (bif.busy !== 1'b0 || bif.out_valid !== 1'b0) begin errors++; $display("FAIL alt_end got busy=%b v=%b exp 0 0", bif.busy, bif.out_valid); end
    endtask

    task automatic test_illegal();
        logic [7:0] bases [3] = '{8'd5, 8'd3, 8'd5};
        logic [3:0] lens  [3] = '{4'd2, 4'd0, 4'd1};
        for (int t = 0; t < 3; t++) begin
            bif.req0 = 1'b1; bif.base0 = bases[t]; bif.len0 = lens[t];
            wait_gnt();
            bif.req0 = 1'b0;
            checks++; if ({bif.gnt0, bif.err} !== {1'b1, t != 2}) begin errors++; $display("FAIL illegal%0d_gnt_err got %b%b exp 1%b", t, bif.gnt0, bif.err, t != 2); end
            checks++; if (bif.busy !== (t == 2)) begin errors++; $display("FAIL illegal%0d_busy got %b exp %b", t, bif.busy, t == 2); end
            @(negedge clk);
            checks++; if (bif.out_valid !== (t == 2) || bif.err !== 1'b0) begin errors++; $display("FAIL illegal%0d_after got v=%b err=%b exp v=%b err=0", t, bif.out_valid, bif.err, t == 2); end
            if (t == 2) begin
                checks++; if (bif.out_data !== 120'hfffd9e0001b200028cfffeadfff993 || bif.out_last !== 1'b1) begin errors++; $display("FAIL legal_beat got %h last=%b exp fffd9e0001b200028cfffeadfff993 last=1", bif.out_data, bif.out_last); end
                @(negedge clk);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        bif.req0 = 1'b1; bif.base0 = 8'd0; bif.len0 = 4'd6;
        wait_gnt();
        bif.req0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bif.out_valid !== 1'b1 || bif.out_data !== rom_row(8'd1)) begin errors++; $display("FAIL arst_pre got v=%b %h exp v=1 %h", bif.out_valid, bif.out_data, rom_row(8'd1)); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bif.out_valid !== 1'b0 || bif.busy !== 1'b0 || bif.out_last !== 1'b0) begin errors++; $display("FAIL arst_clear got v=%b busy=%b last=%b exp 0 0 0", bif.out_valid, bif.busy, bif.out_last); end
        checks++; if (bif.bb_addr !== 8'd0 || bif.out_data !== 120'h0) begin errors++; $display("FAIL arst_data got addr=%0d %h exp 0 0", bif.bb_addr, bif.out_data); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bif.req1 = 1'b1; bif.base1 = 8'd0; bif.len1 = 4'd1;
        wait_gnt();
        bif.req1 = 1'b0;
        checks++; if ({bif.gnt0, bif.gnt1, bif.err} !== 3'b010) begin errors++; $display("FAIL arst_gnt got %b exp 010", {bif.gnt0, bif.gnt1, bif.err}); end
        @(negedge clk);
        checks++; if (bif.out_valid !== 1'b1 || bif.out_id !== 1'b1 || bif.out_last !== 1'b1 || bif.out_data !== rom_row(8'd0)) begin errors++; $display("FAIL arst_beat got v=%b id=%b last=%b %h exp 1 1 1 %h", bif.out_valid, bif.out_id, bif.out_last, bif.out_data, rom_row(8'd0)); end
        @(negedge clk);
        bif.req0 = 1'b1; bif.base0 = 8'd2; bif.len0 = 4'd1;
        bif.req1 = 1'b1; bif.base1 = 8'd3; bif.len1 = 4'd1;
        wait_gnt();
        bif.req0 = 1'b0; bif.req1 = 1'b0;
        checks++; if ({bif.gnt0, bif.gnt1} !== 2'b10) begin errors++; $display("FAIL arst_tie got %b%b exp 10", bif.gnt0, bif.gnt1); end
        @(negedge clk);
        checks++; if (bif.out_data !== rom_row(8'd2) || bif.out_id !== 1'b0) begin errors++; $display("FAIL arst_tie_beat got %h id=%b exp %h id=0", bif.out_data, bif.out_id, rom_row(8'd2)); end
        @(negedge clk);
    endtask

    initial begin
        bif.req0 = 1'b0; bif.base0 = '0; bif.len0 = '0;
        bif.req1 = 1'b0; bif.base1 = '0; bif.len1 = '0;
        bif.out_ready = 1'b1;
        test_reset();
        test_full_burst();
        @(negedge clk);
        test_stall();
        @(negedge clk);
        test_alternate();
        test_illegal();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
